pipelined_addsub: RTL



---
 rtl/pipelined_addsub_pkg.sv | 16 +
 rtl/addsub_seg.sv | 20 ++
 rtl/pipelined_addsub.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_pkg.sv
// rtl/pipelined_addsub_pkg.sv - shared constants and helpers for the pipelined adder/subtractor
package pipelined_addsub_pkg;

    // Bit positions of the ALU flag bus
    localparam int FLAG_CF = 0;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 2;
    localparam int FLAG_ZF = 3;
    localparam int FLAG_W  = 4;

    // Pipeline depth: one stage per SEG-bit slice of the carry chain
    function automatic int stages_of(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// rtl/addsub_seg.sv - combinational SEG-bit adder slice with carry in/out and zero detect
module addsub_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           seg_zero
);

    logic [SEG:0] total;

    assign total    = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    assign sum      = total[SEG-1:0];
    assign cout     = total[SEG];
    assign seg_zero = (total[SEG-1:0] == '0);

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined N-bit adder/subtractor with valid/ready handshake and ALU flags
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             cf,
    output logic             of,
    output logic             sf,
    output logic             zf
);

    localparam int STAGES = stages_of(WIDTH, SEG);
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    if (WIDTH < 2 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of SEG");
    end

    // Per-stage state: operands travel with the partial result so each
    // stage can pick out its own slice; carry/zero chain across stages.
    logic             st_valid [STAGES];
    logic             st_carry [STAGES];
    logic             st_zero  [STAGES];
    logic             st_sub   [STAGES];
    logic [WIDTH-1:0] st_a     [STAGES];
    logic [WIDTH-1:0] st_b     [STAGES];
    logic [WIDTH-1:0] st_res   [STAGES];

    logic             adv;
    logic [WIDTH-1:0] bb;
    logic [FLAG_W-1:0] flags;

    // The whole pipe moves together; it only stalls when the output is held
    assign adv      = !st_valid[LAST] || out_ready;
    assign in_ready = adv;
    assign bb       = b ^ {WIDTH{sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0] seg_a;
        logic [SEG-1:0] seg_b;
        logic [SEG-1:0] seg_sum;
        logic           seg_cin;
        logic           seg_cout;
        logic           seg_zero;

        if (k == 0) begin : g_head
            assign seg_a   = a[SEG-1:0];
            assign seg_b   = bb[SEG-1:0];
            assign seg_cin = sub;

            // Capture the incoming beat and add the lowest slice
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    st_valid[0] <= 1'b0;
                    st_carry[0] <= 1'b0;
                    st_zero[0]  <= 1'b0;
                    st_sub[0]   <= 1'b0;
                    st_a[0]     <= '0;
                    st_b[0]     <= '0;
                    st_res[0]   <= '0;
                end else if (adv) begin
                    st_valid[0]          <= in_valid;
                    st_carry[0]          <= seg_cout;
                    st_zero[0]           <= seg_zero;
                    st_sub[0]            <= sub;
                    st_a[0]              <= a;
                    st_b[0]              <= bb;
                    st_res[0]            <= '0;
                    st_res[0][SEG-1:0]   <= seg_sum;
                end
            end
        end else begin : g_tail
            assign seg_a   = st_a[k-1][k*SEG +: SEG];
            assign seg_b   = st_b[k-1][k*SEG +: SEG];
            assign seg_cin = st_carry[k-1];

            // Add slice k on the carry from the previous stage, carry the rest along
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    st_valid[k] <= 1'b0;
                    st_carry[k] <= 1'b0;
                    st_zero[k]  <= 1'b0;
                    st_sub[k]   <= 1'b0;
                    st_a[k]     <= '0;
                    st_b[k]     <= '0;
                    st_res[k]   <= '0;
                end else if (adv) begin
                    st_valid[k]               <= st_valid[k-1];
                    st_carry[k]               <= seg_cout;
                    st_zero[k]                <= st_zero[k-1] && seg_zero;
                    st_sub[k]                 <= st_sub[k-1];
                    st_a[k]                   <= st_a[k-1];
                    st_b[k]                   <= st_b[k-1];
                    st_res[k]                 <= st_res[k-1];
                    st_res[k][k*SEG +: SEG]   <= seg_sum;
                end
            end
        end

        addsub_seg #(
            .SEG(SEG)
        ) u_seg (
            .a        (seg_a),
            .b        (seg_b),
            .cin      (seg_cin),
            .sum      (seg_sum),
            .cout     (seg_cout),
            .seg_zero (seg_zero)
        );
    end

    // Flag bus derived from the last stage; a/bb MSBs ride in the operand copies
    always_comb begin
        flags          = '0;
        flags[FLAG_CF] = st_carry[LAST] ^ st_sub[LAST];
        flags[FLAG_OF] = (st_a[LAST][MSB] == st_b[LAST][MSB]) &&
                         (st_res[LAST][MSB] != st_a[LAST][MSB]);
        flags[FLAG_SF] = st_res[LAST][MSB];
        flags[FLAG_ZF] = st_zero[LAST];
    end

    assign out_valid = st_valid[LAST];
    assign f         = st_res[LAST];
    assign cout      = st_carry[LAST];
    assign cf        = flags[FLAG_CF];
    assign of        = flags[FLAG_OF];
    assign sf        = flags[FLAG_SF];
    assign zf        = flags[FLAG_ZF];

endmodule
